// File: rtl/rvh_l1d_pkg.sv
// rvh_l1d_pkg: AXI field layouts and constants shared by the
// L1D writeback master and its beat mux.
package rvh_l1d_pkg;

  localparam int MEMNOC_TID_MASTERID_SIZE = 4;
  localparam int MEMNOC_TID_TID_SIZE      = 4;

  localparam int PADDR_W     = 56;
  localparam int AXI_ID_W    = MEMNOC_TID_MASTERID_SIZE
                             + MEMNOC_TID_TID_SIZE;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_DATA_W  = 64;
  localparam int AXI_STRB_W  = 8;
  localparam int AXI_RESP_W  = 2;

  localparam int AXI_AW_W = AXI_ID_W + PADDR_W + AXI_LEN_W
                          + AXI_SIZE_W + AXI_BURST_W;
  localparam int AXI_W_W  = AXI_DATA_W + 1 + AXI_STRB_W;
  localparam int AXI_B_W  = MEMNOC_TID_MASTERID_SIZE
                          + MEMNOC_TID_TID_SIZE + AXI_RESP_W;

  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_8B    = 3'd3;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [PADDR_W-1:0]     LINE_ADDR_MASK = ~PADDR_W'(63);

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [PADDR_W-1:0]     addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } axi_aw_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    logic [AXI_STRB_W-1:0] strb;
  } axi_w_t;

  typedef struct packed {
    logic [MEMNOC_TID_MASTERID_SIZE-1:0] masterid;
    logic [MEMNOC_TID_TID_SIZE-1:0]      tid;
    logic [AXI_RESP_W-1:0]               resp;
  } axi_b_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rvh_l1d_wb_beat_mux.sv
// rvh_l1d_wb_beat_mux: selects one 64-bit beat of the buffered
// line and its byte strobe (RVH_L1D_WB_DIRTY_MASK_EN masks clean beats).
module rvh_l1d_wb_beat_mux
  import rvh_l1d_pkg::*;
#(
  parameter int LINE_BEATS = 8,
  parameter int BEAT_W     = 3
) (
  input  logic [LINE_BEATS*AXI_DATA_W-1:0] line_i,
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
  input  logic [LINE_BEATS-1:0]            dirty_i,
`endif
  input  logic [BEAT_W-1:0]                beat_i,
  output logic [AXI_DATA_W-1:0]            data_o,
  output logic [AXI_STRB_W-1:0]            strb_o
);

  logic [AXI_DATA_W-1:0] beats [LINE_BEATS];

  for (genvar i = 0; i < LINE_BEATS; i++) begin : g_beat
    assign beats[i] = line_i[i*AXI_DATA_W +: AXI_DATA_W];
  end

  assign data_o = beats[beat_i];

  // Clean beats still go out, just with no bytes enabled.
  always_comb begin
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
    strb_o = dirty_i[beat_i] ? 8'hFF : 8'h00;
`else
    strb_o = 8'hFF;
`endif
  end

endmodule

// File: rtl/std_dffrve.sv
// std_dffrve: enabled register with asynchronous active-low
// reset to a supplied value.
module std_dffrve #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] rst_val,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; reset forces rst_val.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   q <= rst_val;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rvh_l1d_wb_axi_master.sv
// rvh_l1d_wb_axi_master: pushes one dirty L1D line per request as an
// AXI INCR burst; RVH_L1D_WB_DIRTY_MASK_EN adds a per-beat dirty mask.
module rvh_l1d_wb_axi_master
  import rvh_l1d_pkg::*;
#(
  parameter int BANK_ID         = 0,
  parameter int LINE_BEATS      = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wb_req_valid,
  output logic                             wb_req_ready,
  input  logic [PADDR_W-1:0]               wb_req_paddr,
  input  logic [LINE_BEATS*AXI_DATA_W-1:0] wb_req_data,
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
  input  logic [LINE_BEATS-1:0]            wb_req_dirty,
`endif
  output logic                             axi_awvalid,
  input  logic                             axi_awready,
  output logic [AXI_AW_W-1:0]              axi_aw,
  output logic                             axi_wvalid,
  input  logic                             axi_wready,
  output logic [AXI_W_W-1:0]               axi_w,
  input  logic                             axi_bvalid,
  output logic                             axi_bready,
  input  logic [AXI_B_W-1:0]               axi_b,
  output logic                             wb_done_valid,
  output logic                             wb_done_err
);

  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TID_W  = MEMNOC_TID_TID_SIZE;
  localparam int MID_W  = MEMNOC_TID_MASTERID_SIZE;

  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [OUT_W-1:0]     MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [MID_W-1:0]     MASTER_ID = MID_W'(BANK_ID);
  localparam logic [AXI_LEN_W-1:0] BURST_LEN = AXI_LEN_W'(LINE_BEATS - 1);

  wb_state_e          state_q, state_d;
  logic               state_raw;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [TID_W-1:0]   tid_q, tid_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [1:0]         done_q, done_d;

  logic [PADDR_W-1:0]               paddr_q;
  logic [LINE_BEATS*AXI_DATA_W-1:0] line_q;
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
  logic [LINE_BEATS-1:0]            dirty_q;
`endif

  axi_aw_t aw;
  axi_w_t  w;
  axi_b_t  b;
  logic    req_hs, aw_hs, w_hs, w_last_hs, b_take, send_end;
  logic    b_unused;

  assign b         = axi_b_t'(axi_b);
  assign b_unused  = ^{b.tid, b.resp[0]};
  assign req_hs    = wb_req_valid & wb_req_ready;
  assign aw_hs     = axi_awvalid & axi_awready;
  assign w_hs      = axi_wvalid & axi_wready;
  assign w_last_hs = w_hs & (beat_q == LAST_BEAT);
  assign send_end  = (aw_done_q | aw_hs) & (w_done_q | w_last_hs);
  assign b_take    = axi_bvalid & axi_bready
                   & (b.masterid == MASTER_ID)
                   & (out_q != '0);

  // Burst FSM: AW and W progress independently, leave once both finish.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    beat_d    = beat_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d   = SEND;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          beat_d    = '0;
        end
      end
      SEND: begin
        if (aw_hs)     aw_done_d = 1'b1;
        if (w_last_hs) w_done_d  = 1'b1;
        if (w_hs)      beat_d = w_last_hs ? '0 : beat_q + 1'b1;
        if (send_end)  state_d = IDLE;
      end
    endcase
  end

  // Outstanding count nets AW issues against accepted B responses.
  always_comb begin
    tid_d  = tid_q + 1'b1;
    out_d  = out_q;
    done_d = {b_take, b_take & b.resp[1]};
    if (aw_hs && !b_take)      out_d = out_q + 1'b1;
    else if (!aw_hs && b_take) out_d = out_q - 1'b1;
  end

  assign state_q = wb_state_e'(state_raw);

  std_dffrve #(.WIDTH(1)) u_state (
    .clk(clk), .rstn(rst), .rst_val(1'b0), .en(1'b1),
    .d(state_d), .q(state_raw)
  );

  std_dffrve #(.WIDTH(1)) u_aw_done (
    .clk(clk), .rstn(rst), .rst_val(1'b0), .en(1'b1),
    .d(aw_done_d), .q(aw_done_q)
  );

  std_dffrve #(.WIDTH(1)) u_w_done (
    .clk(clk), .rstn(rst), .rst_val(1'b0), .en(1'b1),
    .d(w_done_d), .q(w_done_q)
  );

  std_dffrve #(.WIDTH(BEAT_W)) u_beat (
    .clk(clk), .rstn(rst), .rst_val('0), .en(1'b1),
    .d(beat_d), .q(beat_q)
  );

  std_dffrve #(.WIDTH(TID_W)) u_tid (
    .clk(clk), .rstn(rst), .rst_val('0), .en(aw_hs),
    .d(tid_d), .q(tid_q)
  );

  std_dffrve #(.WIDTH(OUT_W)) u_out (
    .clk(clk), .rstn(rst), .rst_val('0), .en(1'b1),
    .d(out_d), .q(out_q)
  );

  std_dffrve #(.WIDTH(2)) u_done (
    .clk(clk), .rstn(rst), .rst_val(2'b00), .en(1'b1),
    .d(done_d), .q(done_q)
  );

  // Line buffer loads on acceptance and is left out of reset.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      paddr_q <= wb_req_paddr;
      line_q  <= wb_req_data;
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
      dirty_q <= wb_req_dirty;
`endif
    end
  end

  rvh_l1d_wb_beat_mux #(
    .LINE_BEATS(LINE_BEATS),
    .BEAT_W    (BEAT_W)
  ) u_beat_mux (
    .line_i (line_q),
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
    .dirty_i(dirty_q),
`endif
    .beat_i (beat_q),
    .data_o (w.data),
    .strb_o (w.strb)
  );

  assign w.last   = (beat_q == LAST_BEAT);
  assign aw.id    = {MASTER_ID, tid_q};
  assign aw.addr  = paddr_q & LINE_ADDR_MASK;
  assign aw.len   = BURST_LEN;
  assign aw.size  = AXI_SIZE_8B;
  assign aw.burst = AXI_BURST_INCR;

  assign wb_req_ready  = (state_q == IDLE) & (out_q < MAX_OUT);
  assign axi_awvalid   = (state_q == SEND) & ~aw_done_q;
  assign axi_wvalid    = (state_q == SEND) & ~w_done_q;
  assign axi_aw        = aw;
  assign axi_w         = w;
  assign axi_bready    = 1'b1;
  assign wb_done_valid = done_q[1];
  assign wb_done_err   = done_q[0];

endmodule

// File: tb/tb_rvh_l1d_wb_axi_master.sv
// tb_rvh_l1d_wb_axi_master: directed and random bursts checked
// against a transaction-level model of the writeback master.
module tb_rvh_l1d_wb_axi_master;

  localparam int LB      = 8;
  localparam int MAX_OUT = 2;
  localparam int BANK    = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_req_valid;
  logic         wb_req_ready;
  logic [55:0]  wb_req_paddr;
  logic [511:0] wb_req_data;
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
  logic [7:0]   wb_req_dirty;
`endif
  logic         axi_awvalid, axi_awready;
  logic [76:0]  axi_aw;
  logic         axi_wvalid, axi_wready;
  logic [72:0]  axi_w;
  logic         axi_bvalid, axi_bready;
  logic [9:0]   axi_b;
  logic         wb_done_valid, wb_done_err;

  rvh_l1d_wb_axi_master #(
    .BANK_ID(BANK), .LINE_BEATS(LB), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_paddr(wb_req_paddr), .wb_req_data(wb_req_data),
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
    .wb_req_dirty(wb_req_dirty),
`endif
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_aw(axi_aw),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_w(axi_w),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_b(axi_b),
    .wb_done_valid(wb_done_valid), .wb_done_err(wb_done_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_busy, m_aw_seen, m_done, m_err;
  int          m_wcnt, m_out;
  logic [3:0]  m_tid;
  logic [55:0] m_addr;
  logic [63:0] m_line [LB];
  logic [7:0]  m_dirty;
  logic [76:0] last_aw;

  task automatic check(input string tag,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_aw_seen = 0; m_done = 0; m_err = 0;
    m_wcnt = 0; m_out = 0; m_tid = '0;
  endtask

  task automatic new_line();
    wb_req_paddr = 56'({$urandom(), $urandom()});
    for (int i = 0; i < LB; i++)
      wb_req_data[i*64 +: 64] = {$urandom(), $urandom()};
    m_dirty = 8'($urandom());
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
    wb_req_dirty = m_dirty;
`endif
  endtask

  // One clock: check outputs, drive inputs, advance model past the edge.
  task automatic cycle(input bit reqv, input bit awr, input bit wr,
                       input bit bv, input logic [9:0] bpl);
    logic        e_ready, e_awv, e_wv;
    logic [76:0] e_aw;
    logic [72:0] e_w;
    logic [7:0]  e_strb;
    e_ready = !m_busy && (m_out < MAX_OUT);
    e_awv   = m_busy && !m_aw_seen;
    e_wv    = m_busy && (m_wcnt < LB);
    check("req_ready", wb_req_ready, e_ready);
    check("awvalid", axi_awvalid, e_awv);
    check("wvalid", axi_wvalid, e_wv);
    check("bready", axi_bready, 1'b1);
    check("done_valid", wb_done_valid, m_done);
    if (m_done) check("done_err", wb_done_err, m_err);
    if (e_awv) begin
      e_aw = {4'(BANK), m_tid, m_addr & ~56'h3f,
              8'(LB - 1), 3'd3, 2'b01};
      check("aw_payload", axi_aw, e_aw);
      if (awr) last_aw = axi_aw;
    end
    if (e_wv) begin
`ifdef RVH_L1D_WB_DIRTY_MASK_EN
      e_strb = m_dirty[m_wcnt] ? 8'hFF : 8'h00;
`else
      e_strb = 8'hFF;
`endif
      e_w = {m_line[m_wcnt], (m_wcnt == LB - 1), e_strb};
      check("w_payload", axi_w, e_w);
    end
    wb_req_valid = reqv;
    axi_awready  = awr;
    axi_wready   = wr;
    axi_bvalid   = bv;
    axi_b        = bpl;
    m_done = 0;
    if (bv && bpl[9:6] == 4'(BANK) && m_out > 0) begin
      m_done = 1; m_err = bpl[1]; m_out--;
    end
    if (e_awv && awr) begin
      m_out++; m_tid++; m_aw_seen = 1;
    end
    if (e_wv && wr) m_wcnt++;
    if (reqv && e_ready) begin
      m_busy = 1; m_aw_seen = 0; m_wcnt = 0;
      m_addr = wb_req_paddr;
      for (int i = 0; i < LB; i++) m_line[i] = wb_req_data[i*64 +: 64];
    end else if (m_busy && m_aw_seen && m_wcnt == LB) begin
      m_busy = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic line_fast();
    new_line();
    cycle(1, 1, 1, 0, '0);
    repeat (LB) cycle(0, 1, 1, 0, '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit tog, bv;
    logic [9:0] bpl;
    rst = 0;
    wb_req_valid = 0; axi_awready = 0; axi_wready = 0;
    axi_bvalid = 0; axi_b = '0;
    last_aw = '0;
    new_line();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", wb_req_ready, 1'b1);
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_done", wb_done_valid, 1'b0);
    rst = 1;
    @(negedge clk);

    // zero-stall line
    new_line();
    wb_req_paddr = 56'h80001234;
    cycle(1, 1, 1, 0, '0);
    n = 0;
    while (!wb_req_ready && n < 20) begin
      cycle(0, 1, 1, 0, '0);
      n++;
    end
    check("zs_idle_cycle", n + 1, 9);
    check("zs_aw_addr", last_aw[68:13], 56'h80001200);
    check("zs_aw_len", last_aw[12:5], 8'd7);
    check("zs_aw_id", last_aw[76:69], 8'h00);
    check("zs_aw_size_burst", last_aw[4:0], 5'b011_01);
    cycle(0, 0, 0, 1, 10'h000);

    // AW accepted late
    new_line();
    cycle(1, 0, 0, 0, '0);
    repeat (LB + 5) cycle(0, 0, 1, 0, '0);
    check("awlate_hold", axi_awvalid, 1'b1);
    check("awlate_send", wb_req_ready, 1'b0);
    cycle(0, 1, 1, 0, '0);
    check("awlate_idle", wb_req_ready, 1'b1);
    cycle(0, 0, 0, 1, 10'h000);

    // W back-pressure
    new_line();
    cycle(1, 0, 0, 0, '0);
    tog = 1; n = 0;
    while (!wb_req_ready && n < 40) begin
      cycle(0, 1, tog, 0, '0);
      tog = !tog; n++;
    end
    check("bp_finish", wb_req_ready, 1'b1);
    cycle(0, 0, 0, 1, 10'h000);

    // outstanding cap and error response
    line_fast();
    line_fast();
    check("cap_ready_low", wb_req_ready, 1'b0);
    cycle(0, 0, 0, 1, {4'h0, 4'h0, 2'b10});
    check("cap_done_valid", wb_done_valid, 1'b1);
    check("cap_done_err", wb_done_err, 1'b1);
    check("cap_ready_back", wb_req_ready, 1'b1);
    cycle(0, 0, 0, 1, {4'h0, 4'h1, 2'b00});

    // B with nothing outstanding
    cycle(0, 0, 0, 1, 10'h000);
    check("uflow_no_done", wb_done_valid, 1'b0);

    // foreign B, then B together with AW
    line_fast();
    cycle(0, 0, 0, 1, {4'h1, 4'h0, 2'b00});
    check("foreign_no_done", wb_done_valid, 1'b0);
    new_line();
    cycle(1, 0, 1, 0, '0);
    cycle(0, 1, 1, 1, {4'h0, 4'h0, 2'b00});
    check("simul_done", wb_done_valid, 1'b1);
    repeat (LB - 1) cycle(0, 1, 1, 0, '0);
    check("simul_out_one", wb_req_ready, 1'b1);
    line_fast();
    check("simul_cap", wb_req_ready, 1'b0);
    cycle(0, 0, 0, 1, 10'h000);
    cycle(0, 0, 0, 1, 10'h000);

    // reset after beat 3
    new_line();
    cycle(1, 0, 1, 0, '0);
    repeat (4) cycle(0, 0, 1, 0, '0);
    rst = 0;
    #1;
    check("rst_mid_awvalid", axi_awvalid, 1'b0);
    check("rst_mid_wvalid", axi_wvalid, 1'b0);
    check("rst_mid_done", wb_done_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    new_line();
    cycle(1, 1, 1, 0, '0);
    cycle(0, 1, 1, 0, '0);
    check("rst_new_tid", last_aw[72:69], 4'h0);
    repeat (LB - 1) cycle(0, 1, 1, 0, '0);
    cycle(0, 0, 0, 1, 10'h000);

    // random traffic
    repeat (800) begin
      new_line();
      bv  = ($urandom_range(0, 3) == 0);
      bpl = {($urandom_range(0, 3) == 0) ? 4'h1 : 4'h0,
             4'($urandom()), 2'($urandom())};
      cycle(1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            bv, bpl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
